// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - ID-stage / branch resolver signal bundle
//
// Purpose: groups the ID-stage resolve inputs, the flush/redirect outputs,
// the BTB training port and the statistics counters of branch_resolve_unit.
// Ports (modport view of the unit = slave):
//   in : id_valid, id_stall, is_jmp, is_jr, is_br, br_taken, pc_1_ID,
//        pred_next_pc, jmp_target, br_target, jr_target
//   out: flush_code, redirect_pc, upd_valid, upd_inval, upd_pc, upd_target,
//        branch_count, mispredict_count
interface branch_resolve_unit_if #(
  parameter int WORD_SIZE       = 16,
  parameter int FLUSH_CODE_SIZE = 3
);
  logic                       id_valid;
  logic                       id_stall;
  logic                       is_jmp;
  logic                       is_jr;
  logic                       is_br;
  logic                       br_taken;
  logic [WORD_SIZE-1:0]       pc_1_ID;
  logic [WORD_SIZE-1:0]       pred_next_pc;
  logic [WORD_SIZE-1:0]       jmp_target;
  logic [WORD_SIZE-1:0]       br_target;
  logic [WORD_SIZE-1:0]       jr_target;
  logic [FLUSH_CODE_SIZE-1:0] flush_code;
  logic [WORD_SIZE-1:0]       redirect_pc;
  logic                       upd_valid;
  logic                       upd_inval;
  logic [WORD_SIZE-1:0]       upd_pc;
  logic [WORD_SIZE-1:0]       upd_target;
  logic [15:0]                branch_count;
  logic [15:0]                mispredict_count;

  modport master (
    output id_valid, id_stall, is_jmp, is_jr, is_br, br_taken,
           pc_1_ID, pred_next_pc, jmp_target, br_target, jr_target,
    input  flush_code, redirect_pc, upd_valid, upd_inval, upd_pc,
           upd_target, branch_count, mispredict_count
  );

  modport slave (
    input  id_valid, id_stall, is_jmp, is_jr, is_br, br_taken,
           pc_1_ID, pred_next_pc, jmp_target, br_target, jr_target,
    output flush_code, redirect_pc, upd_valid, upd_inval, upd_pc,
           upd_target, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - ID-stage branch resolver, BTB trainer and PHT
//
// Purpose: compares the fetch-time predicted next PC of the ID instruction
// with its actual next PC, raises a flush code and redirect PC on mismatch,
// trains the BTB one cycle later (gated by a 2-bit-counter PHT for
// conditional branches) and counts branches and mispredicts.
// Ports:
//   clk     : clock
//   reset_n : synchronous active-low reset
//   bus     : branch_resolve_unit_if.slave (ID inputs, flush/redirect,
//             BTB update port, statistics)
module branch_resolve_unit #(
  parameter int WORD_SIZE       = 16,
  parameter int PHT_IDX_BITS    = 6,
  parameter int FLUSH_CODE_SIZE = 3
) (
  input logic                  clk,
  input logic                  reset_n,
  branch_resolve_unit_if.slave bus
);

  localparam logic [FLUSH_CODE_SIZE-1:0] NICE_PRED = FLUSH_CODE_SIZE'(0);
  localparam logic [FLUSH_CODE_SIZE-1:0] JMP_FLUSH = FLUSH_CODE_SIZE'(1);
  localparam logic [FLUSH_CODE_SIZE-1:0] BR_FLUSH  = FLUSH_CODE_SIZE'(2);
  localparam logic [FLUSH_CODE_SIZE-1:0] NBR_FLUSH = FLUSH_CODE_SIZE'(3);
  localparam logic [FLUSH_CODE_SIZE-1:0] JR_FLUSH  = FLUSH_CODE_SIZE'(4);
  localparam int PHT_DEPTH = 1 << PHT_IDX_BITS;

  typedef enum logic {RESOLVE, SQUASH} state_t;

  state_t state, state_next;

  logic [1:0]                 pht [PHT_DEPTH];
  logic [WORD_SIZE-1:0]       pc_id;
  logic [PHT_IDX_BITS-1:0]    pht_idx;
  logic [1:0]                 cur_ctr;
  logic [1:0]                 new_ctr;
  logic                       accept;
  logic                       any_ctrl;
  logic [WORD_SIZE-1:0]       actual_pc;
  logic [FLUSH_CODE_SIZE-1:0] flush_sel;
  logic                       mispredict;
  logic                       upd_fire;
  logic                       upd_inval_next;

  logic                       upd_valid_q;
  logic                       upd_inval_q;
  logic [WORD_SIZE-1:0]       upd_pc_q;
  logic [WORD_SIZE-1:0]       upd_target_q;
  logic [15:0]                branch_count_q;
  logic [15:0]                mispredict_count_q;

  // PC of the ID instruction itself; wraps 0x0000 -> 0xFFFF.
  assign pc_id    = bus.pc_1_ID - WORD_SIZE'(1);
  assign pht_idx  = pc_id[PHT_IDX_BITS-1:0];
  assign cur_ctr  = pht[pht_idx];
  assign accept   = (state == RESOLVE) && bus.id_valid && !bus.id_stall;
  assign any_ctrl = bus.is_jmp || bus.is_jr || bus.is_br;

  // Saturating 2-bit counter step for the branch being resolved.
  always_comb begin
    new_ctr = cur_ctr;
    if (bus.br_taken) begin
      if (cur_ctr != 2'd3) new_ctr = cur_ctr + 2'd1;
    end else begin
      if (cur_ctr != 2'd0) new_ctr = cur_ctr - 2'd1;
    end
  end

  // Actual next PC and candidate flush code, jmp > jr > br priority.
  always_comb begin
    actual_pc = bus.pc_1_ID;
    flush_sel = NBR_FLUSH;
    if (bus.is_jmp) begin
      actual_pc = bus.jmp_target;
      flush_sel = JMP_FLUSH;
    end else if (bus.is_jr) begin
      actual_pc = bus.jr_target;
      flush_sel = JR_FLUSH;
    end else if (bus.is_br && bus.br_taken) begin
      actual_pc = bus.br_target;
      flush_sel = BR_FLUSH;
    end
  end

  assign mispredict = accept && (actual_pc != bus.pred_next_pc);

  // Unconditional jumps always retrain; branches only retrain when the PHT
  // agrees with the new direction, so one odd outcome does not thrash the
  // BTB. A non-branch that was predicted away is a stale alias: drop it.
  always_comb begin
    upd_fire       = 1'b1;
    upd_inval_next = 1'b1;
    if (bus.is_jmp || bus.is_jr) begin
      upd_inval_next = 1'b0;
    end else if (bus.is_br) begin
      if (bus.br_taken) begin
        upd_fire       = (new_ctr >= 2'd2);
        upd_inval_next = 1'b0;
      end else begin
        upd_fire       = (new_ctr <= 2'd1);
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RESOLVE: if (mispredict) state_next = SQUASH;
      SQUASH:  if (!bus.id_stall) state_next = RESOLVE;
      default: state_next = RESOLVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state              <= RESOLVE;
      upd_valid_q        <= 1'b0;
      upd_inval_q        <= 1'b0;
      upd_pc_q           <= '0;
      upd_target_q       <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      for (int i = 0; i < PHT_DEPTH; i++) pht[i] <= 2'b01;
    end else begin
      state       <= state_next;
      upd_valid_q <= mispredict && upd_fire;
      if (mispredict) begin
        upd_inval_q  <= upd_inval_next;
        upd_pc_q     <= pc_id;
        upd_target_q <= actual_pc;
      end
      if (accept && bus.is_br && !bus.is_jmp && !bus.is_jr) pht[pht_idx] <= new_ctr;
      if (accept && any_ctrl && branch_count_q != 16'hFFFF)
        branch_count_q <= branch_count_q + 16'd1;
      if (mispredict && mispredict_count_q != 16'hFFFF)
        mispredict_count_q <= mispredict_count_q + 16'd1;
    end
  end

  assign bus.flush_code       = (reset_n && mispredict) ? flush_sel : NICE_PRED;
  assign bus.redirect_pc      = !reset_n ? '0 : (mispredict ? actual_pc : bus.pc_1_ID);
  assign bus.upd_valid        = upd_valid_q;
  assign bus.upd_inval        = upd_inval_q;
  assign bus.upd_pc           = upd_pc_q;
  assign bus.upd_target       = upd_target_q;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed self-checking bench for branch_resolve_unit
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.WORD_SIZE(16), .FLUSH_CODE_SIZE(3)) bus_if ();

  branch_resolve_unit #(.WORD_SIZE(16), .PHT_IDX_BITS(6), .FLUSH_CODE_SIZE(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic st, input logic j, input logic r,
                       input logic b, input logic t, input logic [15:0] pc1,
                       input logic [15:0] pred, input logic [15:0] jt,
                       input logic [15:0] bt, input logic [15:0] rt);
    bus_if.id_valid     = v;
    bus_if.id_stall     = st;
    bus_if.is_jmp       = j;
    bus_if.is_jr        = r;
    bus_if.is_br        = b;
    bus_if.br_taken     = t;
    bus_if.pc_1_ID      = pc1;
    bus_if.pred_next_pc = pred;
    bus_if.jmp_target   = jt;
    bus_if.br_target    = bt;
    bus_if.jr_target    = rt;
    #1;
  endtask

  task automatic squash_cycle();
    drive(0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1, 0, 1, 0, 0, 0, 16'h0011, 16'h0022, 16'h0033, 16'h0, 16'h0);
    checks++; if (bus_if.flush_code !== 3'd0) begin failures++; $display("FAIL rst_flush got=%0d exp=0", bus_if.flush_code); end
    checks++; if (bus_if.redirect_pc !== 16'h0) begin failures++; $display("FAIL rst_redirect got=%h exp=0000", bus_if.redirect_pc); end
    step();
    checks++; if (bus_if.upd_valid !== 1'b0) begin failures++; $display("FAIL rst_upd_valid got=%b exp=0", bus_if.upd_valid); end
    checks++; if (bus_if.upd_pc !== 16'h0 || bus_if.upd_target !== 16'h0) begin failures++; $display("FAIL rst_upd_fields got=%h/%h exp=0000/0000", bus_if.upd_pc, bus_if.upd_target); end
    checks++; if (bus_if.branch_count !== 16'd0 || bus_if.mispredict_count !== 16'd0) begin failures++; $display("FAIL rst_counts got=%0d/%0d exp=0/0", bus_if.branch_count, bus_if.mispredict_count); end
  endtask

  task automatic test_no_branch();
    reset_n = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 16'h0011, 16'h0011, 16'h0, 16'h0, 16'h0);
    checks++; if (bus_if.flush_code !== 3'd0) begin failures++; $display("FAIL nb_flush got=%0d exp=0", bus_if.flush_code); end
    checks++; if (bus_if.redirect_pc !== 16'h0011) begin failures++; $display("FAIL nb_redirect got=%h exp=0011", bus_if.redirect_pc); end
    step();
    checks++; if (bus_if.upd_valid !== 1'b0) begin failures++; $display("FAIL nb_upd_valid got=%b exp=0", bus_if.upd_valid); end
    checks++; if (bus_if.branch_count !== 16'd0 || bus_if.mispredict_count !== 16'd0) begin failures++; $display("FAIL nb_counts got=%0d/%0d exp=0/0", bus_if.branch_count, bus_if.mispredict_count); end
  endtask

  task automatic test_jmp();
    drive(1, 0, 1, 0, 0, 0, 16'h0021, 16'h0021, 16'h0100, 16'h0, 16'h0);
    checks++; if (bus_if.flush_code !== 3'd1) begin failures++; $display("FAIL jmp_flush got=%0d exp=1", bus_if.flush_code); end
    checks++; if (bus_if.redirect_pc !== 16'h0100) begin failures++; $display("FAIL jmp_redirect got=%h exp=0100", bus_if.redirect_pc); end
    step();
    checks++; if (bus_if.upd_valid !== 1'b1 || bus_if.upd_inval !== 1'b0) begin failures++; $display("FAIL jmp_upd got=%b/%b exp=1/0", bus_if.upd_valid, bus_if.upd_inval); end
    checks++; if (bus_if.upd_pc !== 16'h0020 || bus_if.upd_target !== 16'h0100) begin failures++; $display("FAIL jmp_upd_fields got=%h/%h exp=0020/0100", bus_if.upd_pc, bus_if.upd_target); end
    checks++; if (bus_if.branch_count !== 16'd1 || bus_if.mispredict_count !== 16'd1) begin failures++; $display("FAIL jmp_counts got=%0d/%0d exp=1/1", bus_if.branch_count, bus_if.mispredict_count); end
    // wrong-path jmp in SQUASH must be ignored
    drive(1, 0, 1, 0, 0, 0, 16'h0101, 16'h0101, 16'h0200, 16'h0, 16'h0);
    checks++; if (bus_if.flush_code !== 3'd0) begin failures++; $display("FAIL squash_flush got=%0d exp=0", bus_if.flush_code); end
    checks++; if (bus_if.redirect_pc !== 16'h0101) begin failures++; $display("FAIL squash_redirect got=%h exp=0101", bus_if.redirect_pc); end
    step();
    checks++; if (bus_if.upd_valid !== 1'b0) begin failures++; $display("FAIL squash_upd got=%b exp=0", bus_if.upd_valid); end
    checks++; if (bus_if.branch_count !== 16'd1 || bus_if.mispredict_count !== 16'd1) begin failures++; $display("FAIL squash_counts got=%0d/%0d exp=1/1", bus_if.branch_count, bus_if.mispredict_count); end
  endtask

  task automatic test_branch();
    // PHT[0x00]=01; taken -> 10, write
    drive(1, 0, 0, 0, 1, 1, 16'h0041, 16'h0041, 16'h0, 16'h0050, 16'h0);
    checks++; if (bus_if.flush_code !== 3'd2) begin failures++; $display("FAIL br_t_flush got=%0d exp=2", bus_if.flush_code); end
    checks++; if (bus_if.redirect_pc !== 16'h0050) begin failures++; $display("FAIL br_t_redirect got=%h exp=0050", bus_if.redirect_pc); end
    step();
    checks++; if (bus_if.upd_valid !== 1'b1 || bus_if.upd_inval !== 1'b0 || bus_if.upd_pc !== 16'h0040 || bus_if.upd_target !== 16'h0050) begin failures++; $display("FAIL br_t_upd got=%b/%b/%h/%h exp=1/0/0040/0050", bus_if.upd_valid, bus_if.upd_inval, bus_if.upd_pc, bus_if.upd_target); end
    squash_cycle();
    // 10 -> 01, not-taken mispredict invalidates
    drive(1, 0, 0, 0, 1, 0, 16'h0041, 16'h0050, 16'h0, 16'h0050, 16'h0);
    checks++; if (bus_if.flush_code !== 3'd3) begin failures++; $display("FAIL br_nt_flush got=%0d exp=3", bus_if.flush_code); end
    checks++; if (bus_if.redirect_pc !== 16'h0041) begin failures++; $display("FAIL br_nt_redirect got=%h exp=0041", bus_if.redirect_pc); end
    step();
    checks++; if (bus_if.upd_valid !== 1'b1 || bus_if.upd_inval !== 1'b1 || bus_if.upd_pc !== 16'h0040) begin failures++; $display("FAIL br_nt_upd got=%b/%b/%h exp=1/1/0040", bus_if.upd_valid, bus_if.upd_inval, bus_if.upd_pc); end
    squash_cycle();
    // 01 -> 00, correctly predicted
    drive(1, 0, 0, 0, 1, 0, 16'h0041, 16'h0041, 16'h0, 16'h0050, 16'h0);
    checks++; if (bus_if.flush_code !== 3'd0) begin failures++; $display("FAIL br_ok_flush got=%0d exp=0", bus_if.flush_code); end
    step();
    checks++; if (bus_if.upd_valid !== 1'b0) begin failures++; $display("FAIL br_ok_upd got=%b exp=0", bus_if.upd_valid); end
    // 00 -> 01, taken mispredict but counter too weak to write
    drive(1, 0, 0, 0, 1, 1, 16'h0041, 16'h0041, 16'h0, 16'h0050, 16'h0);
    checks++; if (bus_if.flush_code !== 3'd2) begin failures++; $display("FAIL br_weak_flush got=%0d exp=2", bus_if.flush_code); end
    step();
    checks++; if (bus_if.upd_valid !== 1'b0) begin failures++; $display("FAIL br_weak_upd got=%b exp=0", bus_if.upd_valid); end
    checks++; if (bus_if.branch_count !== 16'd5 || bus_if.mispredict_count !== 16'd4) begin failures++; $display("FAIL br_counts got=%0d/%0d exp=5/4", bus_if.branch_count, bus_if.mispredict_count); end
    squash_cycle();
  endtask

  task automatic test_pht_saturation();
    // counter at 01; four taken -> saturates at 11
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, 1, 1, 16'h0041, 16'h0050, 16'h0, 16'h0050, 16'h0);
      checks++; if (bus_if.flush_code !== 3'd0) begin failures++; $display("FAIL sat_taken_flush[%0d] got=%0d exp=0", i, bus_if.flush_code); end
      step();
    end
    // 11 -> 10: still strong enough, no invalidate
    drive(1, 0, 0, 0, 1, 0, 16'h0041, 16'h0050, 16'h0, 16'h0050, 16'h0);
    checks++; if (bus_if.flush_code !== 3'd3) begin failures++; $display("FAIL sat_nt1_flush got=%0d exp=3", bus_if.flush_code); end
    step();
    checks++; if (bus_if.upd_valid !== 1'b0) begin failures++; $display("FAIL sat_nt1_upd got=%b exp=0", bus_if.upd_valid); end
    squash_cycle();
    // 10 -> 01: invalidate
    drive(1, 0, 0, 0, 1, 0, 16'h0041, 16'h0050, 16'h0, 16'h0050, 16'h0);
    step();
    checks++; if (bus_if.upd_valid !== 1'b1 || bus_if.upd_inval !== 1'b1) begin failures++; $display("FAIL sat_nt2_upd got=%b/%b exp=1/1", bus_if.upd_valid, bus_if.upd_inval); end
    checks++; if (bus_if.branch_count !== 16'd11 || bus_if.mispredict_count !== 16'd6) begin failures++; $display("FAIL sat_counts got=%0d/%0d exp=11/6", bus_if.branch_count, bus_if.mispredict_count); end
    squash_cycle();
  endtask

  task automatic test_stall();
    drive(1, 1, 0, 1, 0, 0, 16'h0061, 16'h0061, 16'h0, 16'h0, 16'h0200);
    checks++; if (bus_if.flush_code !== 3'd0) begin failures++; $display("FAIL stall_flush got=%0d exp=0", bus_if.flush_code); end
    step();
    checks++; if (bus_if.upd_valid !== 1'b0 || bus_if.branch_count !== 16'd11) begin failures++; $display("FAIL stall_hold got=%b/%0d exp=0/11", bus_if.upd_valid, bus_if.branch_count); end
    drive(1, 0, 0, 1, 0, 0, 16'h0061, 16'h0061, 16'h0, 16'h0, 16'h0200);
    checks++; if (bus_if.flush_code !== 3'd4) begin failures++; $display("FAIL jr_flush got=%0d exp=4", bus_if.flush_code); end
    checks++; if (bus_if.redirect_pc !== 16'h0200) begin failures++; $display("FAIL jr_redirect got=%h exp=0200", bus_if.redirect_pc); end
    step();
    checks++; if (bus_if.upd_valid !== 1'b1 || bus_if.upd_inval !== 1'b0 || bus_if.upd_pc !== 16'h0060 || bus_if.upd_target !== 16'h0200) begin failures++; $display("FAIL jr_upd got=%b/%b/%h/%h exp=1/0/0060/0200", bus_if.upd_valid, bus_if.upd_inval, bus_if.upd_pc, bus_if.upd_target); end
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 0, 0, 16'h0201, 16'h0201, 16'h0300, 16'h0, 16'h0);
      checks++; if (bus_if.flush_code !== 3'd0) begin failures++; $display("FAIL sq_stall_flush[%0d] got=%0d exp=0", i, bus_if.flush_code); end
      step();
    end
    // released: this cycle still SQUASH, next cycle RESOLVE
    drive(1, 0, 1, 0, 0, 0, 16'h0201, 16'h0201, 16'h0300, 16'h0, 16'h0);
    checks++; if (bus_if.flush_code !== 3'd0) begin failures++; $display("FAIL sq_release_flush got=%0d exp=0", bus_if.flush_code); end
    step();
    drive(1, 0, 1, 0, 0, 0, 16'h0201, 16'h0201, 16'h0300, 16'h0, 16'h0);
    checks++; if (bus_if.flush_code !== 3'd1) begin failures++; $display("FAIL resolve_again_flush got=%0d exp=1", bus_if.flush_code); end
    step();
    checks++; if (bus_if.branch_count !== 16'd13 || bus_if.mispredict_count !== 16'd8) begin failures++; $display("FAIL stall_counts got=%0d/%0d exp=13/8", bus_if.branch_count, bus_if.mispredict_count); end
    squash_cycle();
  endtask

  task automatic test_alias();
    drive(1, 0, 0, 0, 0, 0, 16'h0091, 16'h0500, 16'h0, 16'h0, 16'h0);
    checks++; if (bus_if.flush_code !== 3'd3 || bus_if.redirect_pc !== 16'h0091) begin failures++; $display("FAIL alias_flush got=%0d/%h exp=3/0091", bus_if.flush_code, bus_if.redirect_pc); end
    step();
    checks++; if (bus_if.upd_valid !== 1'b1 || bus_if.upd_inval !== 1'b1 || bus_if.upd_pc !== 16'h0090) begin failures++; $display("FAIL alias_upd got=%b/%b/%h exp=1/1/0090", bus_if.upd_valid, bus_if.upd_inval, bus_if.upd_pc); end
    squash_cycle();
    drive(1, 0, 0, 0, 0, 0, 16'h0000, 16'h1234, 16'h0, 16'h0, 16'h0);
    checks++; if (bus_if.flush_code !== 3'd3 || bus_if.redirect_pc !== 16'h0000) begin failures++; $display("FAIL wrap_flush got=%0d/%h exp=3/0000", bus_if.flush_code, bus_if.redirect_pc); end
    step();
    checks++; if (bus_if.upd_valid !== 1'b1 || bus_if.upd_pc !== 16'hFFFF) begin failures++; $display("FAIL wrap_upd_pc got=%b/%h exp=1/ffff", bus_if.upd_valid, bus_if.upd_pc); end
    checks++; if (bus_if.branch_count !== 16'd13 || bus_if.mispredict_count !== 16'd10) begin failures++; $display("FAIL alias_counts got=%0d/%0d exp=13/10", bus_if.branch_count, bus_if.mispredict_count); end
    squash_cycle();
  endtask

  task automatic test_priority();
    drive(1, 0, 1, 0, 1, 1, 16'h0081, 16'h0081, 16'h0300, 16'h0400, 16'h0);
    checks++; if (bus_if.flush_code !== 3'd1 || bus_if.redirect_pc !== 16'h0300) begin failures++; $display("FAIL prio_flush got=%0d/%h exp=1/0300", bus_if.flush_code, bus_if.redirect_pc); end
    step();
    checks++; if (bus_if.upd_valid !== 1'b1 || bus_if.upd_inval !== 1'b0 || bus_if.upd_target !== 16'h0300) begin failures++; $display("FAIL prio_upd got=%b/%b/%h exp=1/0/0300", bus_if.upd_valid, bus_if.upd_inval, bus_if.upd_target); end
    checks++; if (bus_if.branch_count !== 16'd14 || bus_if.mispredict_count !== 16'd11) begin failures++; $display("FAIL prio_counts got=%0d/%0d exp=14/11", bus_if.branch_count, bus_if.mispredict_count); end
    squash_cycle();
  endtask

  task automatic test_reset_mid();
    // drive PHT[0x20] down to 00
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0, 1, 0, 16'h00A1, 16'h00A1, 16'h0, 16'h0700, 16'h0);
      step();
    end
    drive(1, 0, 1, 0, 0, 0, 16'h00B1, 16'h00B1, 16'h0600, 16'h0, 16'h0);
    step();
    checks++; if (bus_if.upd_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_upd got=%b exp=1", bus_if.upd_valid); end
    reset_n = 1'b0;
    #1;
    checks++; if (bus_if.flush_code !== 3'd0 || bus_if.redirect_pc !== 16'h0) begin failures++; $display("FAIL mid_rst_outs got=%0d/%h exp=0/0000", bus_if.flush_code, bus_if.redirect_pc); end
    step();
    checks++; if (bus_if.upd_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_upd got=%b exp=0", bus_if.upd_valid); end
    checks++; if (bus_if.branch_count !== 16'd0 || bus_if.mispredict_count !== 16'd0) begin failures++; $display("FAIL mid_rst_counts got=%0d/%0d exp=0/0", bus_if.branch_count, bus_if.mispredict_count); end
    reset_n = 1'b1;
    // PHT back at 01 -> taken gives 10 -> write; back in RESOLVE
    drive(1, 0, 0, 0, 1, 1, 16'h00A1, 16'h00A1, 16'h0, 16'h0700, 16'h0);
    checks++; if (bus_if.flush_code !== 3'd2) begin failures++; $display("FAIL mid_post_flush got=%0d exp=2", bus_if.flush_code); end
    step();
    checks++; if (bus_if.upd_valid !== 1'b1 || bus_if.upd_inval !== 1'b0 || bus_if.upd_target !== 16'h0700) begin failures++; $display("FAIL mid_pht_reset got=%b/%b/%h exp=1/0/0700", bus_if.upd_valid, bus_if.upd_inval, bus_if.upd_target); end
  endtask

  task automatic test_count_saturation();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    drive(1, 0, 1, 0, 0, 0, 16'h0011, 16'h0050, 16'h0050, 16'h0, 16'h0);
    repeat (65535) @(posedge clk);
    #1;
    checks++; if (bus_if.branch_count !== 16'hFFFF || bus_if.mispredict_count !== 16'd0) begin failures++; $display("FAIL cnt_max got=%h/%0d exp=ffff/0", bus_if.branch_count, bus_if.mispredict_count); end
    step();
    checks++; if (bus_if.branch_count !== 16'hFFFF) begin failures++; $display("FAIL cnt_sat1 got=%h exp=ffff", bus_if.branch_count); end
    step();
    checks++; if (bus_if.branch_count !== 16'hFFFF) begin failures++; $display("FAIL cnt_sat2 got=%h exp=ffff", bus_if.branch_count); end
  endtask

  initial begin
    test_reset();
    test_no_branch();
    test_jmp();
    test_branch();
    test_pht_saturation();
    test_stall();
    test_alias();
    test_priority();
    test_reset_mid();
    test_count_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
Name:
branch_resolve_unit

Overview:
ID-stage resolver for the 16-bit pipelined core. It compares the fetch-time BTB prediction carried with each instruction against the actual next PC. On a mismatch it emits the flush code and redirect PC. It also trains the BTB through a registered update/invalidate port, gated by a 2-bit-counter pattern history table (PHT) for conditional branches, and maintains branch and mispredict statistics.

Parameters:
WORD_SIZE, 16, data/address width
PHT_IDX_BITS, 6, PHT index width (64 entries of 2-bit counters)
FLUSH_CODE_SIZE, 3, flush code width

Ports:
clk  in  1  clock
reset_n  in  1  reset, synchronous, active-low
id_valid  in  1  ID holds a real instruction
id_stall  in  1  ID is held this cycle
is_jmp  in  1  ID instruction is a direct jump
is_jr  in  1  ID instruction is a register jump
is_br  in  1  ID instruction is a conditional branch
br_taken  in  1  resolved branch condition
pc_1_ID  in  WORD_SIZE  PC+1 of the ID instruction
pred_next_pc  in  WORD_SIZE  next PC that fetch used for this instruction
jmp_target  in  WORD_SIZE  direct jump target
br_target  in  WORD_SIZE  branch target
jr_target  in  WORD_SIZE  forwarded register value
flush_code  out  FLUSH_CODE_SIZE  0 NICE_PRED, 1 JMP_FLUSH, 2 BR_FLUSH, 3 NBR_FLUSH, 4 JR_FLUSH
redirect_pc  out  WORD_SIZE  corrected fetch PC, valid when flush_code != 0
upd_valid  out  1  one-cycle BTB write/invalidate pulse
upd_inval  out  1  1 = invalidate the entry, 0 = write upd_target
upd_pc  out  WORD_SIZE  PC of the trained instruction
upd_target  out  WORD_SIZE  target to write
branch_count  out  16  resolved control-flow instructions
mispredict_count  out  16  flushes issued

Behaviour:
- Reset (clk edge with reset_n=0):
  - state=RESOLVE.
  - All PHT entries = 2'b01 (weakly not-taken).
  - upd_valid, upd_inval, upd_pc, upd_target, branch_count, mispredict_count = 0.
  - flush_code=0 and redirect_pc=0 while reset_n=0.
  - Reset mid-operation discards any pending update.
- Accepted instruction: "accept" = state RESOLVE, id_valid=1, id_stall=0.
- Decode priority: is_jmp > is_jr > is_br. Multiple asserted flags are resolved by this priority.
- Actual next PC:
  - jmp → jmp_target.
  - jr → jr_target.
  - br taken → br_target.
  - otherwise → pc_1_ID.
- Mispredict: accept AND actual != pred_next_pc. The comparison is a full 16-bit equality.
- flush_code is combinational. It is 0 unless mispredict; on mispredict:
  - jmp → 1.
  - br taken → 2.
  - br not-taken, or non-branch → 3.
  - jr → 4.
- redirect_pc = actual next PC on mispredict, else pc_1_ID.
- PHT:
  - Index = (pc_1_ID−1)[PHT_IDX_BITS-1:0].
  - Updated on every accepted is_br at the clock edge: increment if taken, else decrement.
  - Counters saturate at 3 and 0.
  - new_ctr denotes the post-update value.
- BTB training is registered; the upd_* fields are valid exactly the cycle after the mispredict.
  - upd_pc = pc_1_ID−1, computed mod 2^16 (0x0000 → 0xFFFF).
  - jmp or jr mispredict → write (upd_inval=0), upd_target = actual.
  - br taken mispredict → write only if new_ctr ≥ 2.
  - br not-taken mispredict → invalidate only if new_ctr ≤ 1.
  - Non-branch mispredict (stale alias) → invalidate.
  - Otherwise upd_valid=0 the next cycle.
- State machine:
  - RESOLVE → SQUASH on any nonzero flush.
  - SQUASH: the wrong-path instruction is in ID. Outputs flush_code=0, no PHT/counter/update activity, inputs ignored.
  - SQUASH → RESOLVE on the first cycle with id_stall=0; it stays in SQUASH while stalled.
- Stall or id_valid=0 in RESOLVE: flush_code=0, no PHT change, no update, counters unchanged.
- Statistics:
  - branch_count increments on each accepted instruction with any is_* flag.
  - mispredict_count increments on each nonzero flush.
  - Both saturate at 0xFFFF (no wrap).

Test Plan:
- Reset, then non-branch accept with pc_1_ID=0x0011, pred=0x0011 → flush_code=0, redirect_pc=0x0011, no upd_valid, counts 0/0.
- jmp at pc_1_ID=0x0021, pred=0x0021, jmp_target=0x0100 → flush=1, redirect=0x0100. Next cycle: upd_valid=1, upd_inval=0, upd_pc=0x0020, upd_target=0x0100, state SQUASH. The following instruction is ignored even with is_jmp set.
- br at pc 0x0040, taken, target 0x0050, pred 0x0041, PHT=01 → flush=2, new_ctr=2, write issued. Repeat not-taken with pred 0x0050 → flush=3, new_ctr=1, invalidate issued. Third time not-taken with pred 0x0041 → flush=0, ctr=0.
- Saturation: four taken branches at the same index → ctr stays 3. With branch_count preloaded near max, 0xFFFF plus one more branch → stays 0xFFFF.
- Stalls: id_stall=1 during a mispredicting jr → flush 0. Release → flush=4, redirect=jr_target. Stall held in SQUASH for 3 cycles → remains SQUASH.
- is_jmp and is_br both set → jmp wins. reset_n=0 the cycle after a mispredict → upd_valid=0, PHT entries back to 01.
